// File: rtl/mips_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mips_run_ctrl
// Purpose  : Run controller for Lite_MIPS: reset/start sequencing, clock-enable
//            gating, halt / cycle-limit stop and one-cycle result capture strobe.
// Revision : 1.0
// ============================================================================
module mips_run_ctrl #(
    parameter int W          = 32,
    parameter int L          = 6,
    parameter int CC         = 60,
    parameter int RST_CYCLES = 2,
    parameter int CW         = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [W*(2**L)-1:0]  inst_mem_flat,
    input  logic [L-1:0]         pc_current,
    output logic                 core_rst,
    output logic                 core_en,
    output logic                 snapshot_en,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           stop_reason,
    output logic [CW-1:0]        cycle_count
);

    localparam int N  = 2**L;
    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RST     = 3'd1,
        S_RUN     = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [RW-1:0]   r_rst_cnt;
    logic [CW-1:0]   r_cycle_count;
    logic [1:0]      r_stop_reason;

    logic [W-1:0]    w_mem [N];
    logic [L-1:0]    w_pc_next;
    logic            w_halt_now;
    logic            w_lim_now;
    logic            w_stop_now;
    logic            w_clear;
    logic            w_load_reason;
    logic [1:0]      w_reason;

    for (genvar g = 0; g < N; g++) begin : g_words
        assign w_mem[g] = inst_mem_flat[(g+1)*W-1 -: W];
    end

    // PC+1 wraps naturally at N-1 because it is held in L bits
    assign w_pc_next  = pc_current + 1'b1;
    assign w_halt_now = (w_mem[pc_current] == '0) && (w_mem[w_pc_next] == '0);
    assign w_lim_now  = (r_cycle_count == CW'(CC));
    assign w_stop_now = w_halt_now | w_lim_now;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        core_rst      = 1'b0;
        core_en       = 1'b0;
        snapshot_en   = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        w_clear       = 1'b0;
        w_load_reason = 1'b0;
        w_reason      = 2'b00;
        case (r_state)
            S_IDLE: begin
                core_rst = 1'b1;
                if (start) begin
                    w_next  = S_RST;
                    w_clear = 1'b1;
                end
            end
            S_RST: begin
                core_rst = 1'b1;
                busy     = 1'b1;
                if (abort) begin
                    w_next        = S_IDLE;
                    w_load_reason = 1'b1;
                    w_reason      = 2'b11;
                end else if (r_rst_cnt == RW'(RST_CYCLES - 1)) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                busy    = 1'b1;
                // Combinational enable keeps the stopping cycle from advancing the core
                core_en = !w_stop_now && !abort;
                if (abort) begin
                    w_next        = S_IDLE;
                    w_load_reason = 1'b1;
                    w_reason      = 2'b11;
                end else if (w_stop_now) begin
                    w_next        = S_CAPTURE;
                    w_load_reason = 1'b1;
                    w_reason      = {w_lim_now, w_halt_now};
                end
            end
            S_CAPTURE: begin
                busy        = 1'b1;
                snapshot_en = 1'b1;
                w_next      = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_next  = S_RST;
                    w_clear = 1'b1;
                end
            end
            default: begin
                core_rst = 1'b1;
                w_next   = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_cnt     <= '0;
            r_cycle_count <= '0;
            r_stop_reason <= 2'b00;
        end else begin
            r_rst_cnt <= (r_state == S_RST) ? r_rst_cnt + 1'b1 : '0;
            if (w_clear) begin
                r_cycle_count <= '0;
            end else if (core_en) begin
                r_cycle_count <= r_cycle_count + 1'b1;
            end
            if (w_clear) begin
                r_stop_reason <= 2'b00;
            end else if (w_load_reason) begin
                r_stop_reason <= w_reason;
            end
        end
    end

    assign stop_reason = r_stop_reason;
    assign cycle_count = r_cycle_count;

endmodule
`default_nettype wire

// File: tb/tb_mips_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_run_ctrl
// Purpose  : Self-checking bench for mips_run_ctrl with a behavioural core PC
//            model, a vector table, corner sequences and randomized runs.
// Revision : 1.0
// ============================================================================
module tb_mips_run_ctrl;

    localparam int W    = 32;
    localparam int L    = 6;
    localparam int N    = 64;
    localparam int RSTC = 2;
    localparam int CW   = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic sel = 1'b0;
    logic [L-1:0] pc0 = '0;

    logic [W-1:0]   img [N];
    logic [W*N-1:0] img_flat;

    for (genvar g = 0; g < N; g++) begin : g_flat
        assign img_flat[g*W +: W] = img[g];
    end

    logic a_core_rst, a_core_en, a_snap, a_busy, a_done;
    logic b_core_rst, b_core_en, b_snap, b_busy, b_done;
    logic [1:0]    a_reason, b_reason;
    logic [CW-1:0] a_count, b_count;
    logic [L-1:0]  pc_a, pc_b;

    logic core_rst, core_en, snapshot_en, busy, done;
    logic [1:0]    stop_reason;
    logic [CW-1:0] cycle_count;

    mips_run_ctrl #(.W(W), .L(L), .CC(60), .RST_CYCLES(RSTC), .CW(CW)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start & ~sel), .abort(abort & ~sel),
        .inst_mem_flat(img_flat), .pc_current(pc_a),
        .core_rst(a_core_rst), .core_en(a_core_en), .snapshot_en(a_snap),
        .busy(a_busy), .done(a_done), .stop_reason(a_reason), .cycle_count(a_count)
    );

    mips_run_ctrl #(.W(W), .L(L), .CC(4), .RST_CYCLES(RSTC), .CW(CW)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start & sel), .abort(abort & sel),
        .inst_mem_flat(img_flat), .pc_current(pc_b),
        .core_rst(b_core_rst), .core_en(b_core_en), .snapshot_en(b_snap),
        .busy(b_busy), .done(b_done), .stop_reason(b_reason), .cycle_count(b_count)
    );

    assign core_rst    = sel ? b_core_rst : a_core_rst;
    assign core_en     = sel ? b_core_en  : a_core_en;
    assign snapshot_en = sel ? b_snap     : a_snap;
    assign busy        = sel ? b_busy     : a_busy;
    assign done        = sel ? b_done     : a_done;
    assign stop_reason = sel ? b_reason   : a_reason;
    assign cycle_count = sel ? b_count    : a_count;

    // Minimal core stand-in: PC restarts at pc0 under reset, steps when enabled
    always_ff @(posedge clk) begin
        if (a_core_rst) pc_a <= pc0; else if (a_core_en) pc_a <= pc_a + 1'b1;
        if (b_core_rst) pc_b <= pc0; else if (b_core_en) pc_b <= pc_b + 1'b1;
    end

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_img(input int kind);
        for (int g = 0; g < N; g++) img[g] = 32'h2000_0000 + 32'(g) + 1;
        case (kind)
            0: begin img[5] = '0; img[6] = '0; end
            2: begin img[4] = '0; img[5] = '0; end
            3: begin img[63] = '0; img[0] = '0; end
            default: ;
        endcase
    endtask

    // Reference: walk the program from pc0 counting enabled cycles
    function automatic void model(input int cc, input int p0, input int ab,
                                  output logic [1:0] reason, output int cnt, output int snap);
        int  pc;
        int  n;
        bit  h;
        bit  l;
        pc = p0; n = 0;
        reason = 2'b00; cnt = -1; snap = 0;
        for (int r = 1; r <= cc + 1; r++) begin
            h = (img[pc] == 0) && (img[(pc + 1) % N] == 0);
            l = (n == cc);
            if (r == ab) begin reason = 2'b11; cnt = n; snap = 0; return; end
            if (h || l) begin reason = {l, h}; cnt = n; snap = 1; return; end
            n++;
            pc = (pc + 1) % N;
        end
    endfunction

    task automatic do_run(input logic s, input int abort_at,
                          output int en_n, output int snap_n, output int rst_c, output int lat,
                          output int trk_bad, output int en_bad, output logic [CW+1:0] first_vals,
                          output bit tmo);
        int run_idx;
        bit in_run;
        run_idx = 0; en_n = 0; snap_n = 0; rst_c = 0; lat = -1;
        trk_bad = 0; en_bad = 0; tmo = 1; first_vals = 'x;
        sel = s;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            abort = 1'b0;
            in_run = busy && !core_rst && !snapshot_en;
            if (in_run) begin
                run_idx++;
                if (run_idx == abort_at) abort = 1'b1;
            end
            #1;
            if (c == 0) first_vals = {stop_reason, cycle_count};
            if (!busy) begin tmo = 0; break; end
            if (core_rst) rst_c++;
            if (cycle_count != CW'(en_n)) trk_bad++;
            if (core_en) begin
                if (lat < 0) lat = c;
                en_n++;
                if (!in_run) en_bad++;
            end
            if (snapshot_en) snap_n++;
        end
        abort = 1'b0;
    endtask

    task automatic run_and_check(input string name, input logic s, input int p0, input int ab,
                                 input logic [1:0] exp_reason, input int exp_cnt, input int exp_snap);
        int en_n, snap_n, rst_c, lat, trk_bad, en_bad;
        logic [CW+1:0] fv;
        bit tmo;
        pc0 = L'(p0);
        do_run(s, ab, en_n, snap_n, rst_c, lat, trk_bad, en_bad, fv, tmo);
        check({name, ".timeout"}, 64'(tmo), 0);
        check({name, ".cleared"}, 64'(fv), 0);
        check({name, ".rst_cycles"}, 64'(rst_c), RSTC);
        check({name, ".en_cycles"}, 64'(en_n), 64'(exp_cnt));
        check({name, ".snapshots"}, 64'(snap_n), 64'(exp_snap));
        check({name, ".stop_reason"}, 64'(stop_reason), 64'(exp_reason));
        check({name, ".cycle_count"}, 64'(cycle_count), 64'(exp_cnt));
        check({name, ".done"}, 64'(done), 64'(exp_snap));
        check({name, ".core_rst_after"}, 64'(core_rst), 64'(exp_snap == 0));
        check({name, ".count_track"}, 64'(trk_bad), 0);
        check({name, ".en_outside_run"}, 64'(en_bad), 0);
        if (exp_cnt > 0) check({name, ".latency"}, 64'(lat), RSTC);
    endtask

    typedef struct {
        int         kind;
        int         p0;
        int         abort_at;
        logic       s;
        logic [1:0] reason;
        int         cnt;
        int         snap;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [1:0] m_reason;
        int m_cnt, m_snap, ab, p;
        logic s;
        bit seen;

        vecs[0] = '{0,  0, 0, 1'b0, 2'b01,  5, 1};  // halt at zero pair 5,6
        vecs[1] = '{1,  0, 0, 1'b0, 2'b10, 60, 1};  // cycle limit
        vecs[2] = '{2,  0, 0, 1'b1, 2'b11,  4, 1};  // halt and limit together
        vecs[3] = '{3, 60, 0, 1'b0, 2'b01,  3, 1};  // halt across PC wrap
        vecs[4] = '{0,  0, 0, 1'b0, 2'b01,  5, 1};  // restart from DONE
        vecs[5] = '{0,  0, 3, 1'b0, 2'b11,  2, 0};  // abort on 3rd RUN cycle
        vecs[6] = '{0,  0, 0, 1'b1, 2'b10,  4, 1};  // limit only, small CC

        set_img(0);
        #12;
        check("reset_a", 64'({a_core_rst, a_core_en, a_snap, a_busy, a_done, a_reason, a_count}),
              64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'd0}));
        check("reset_b", 64'({b_core_rst, b_core_en, b_snap, b_busy, b_done, b_reason, b_count}),
              64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'd0}));
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            set_img(vecs[i].kind);
            run_and_check($sformatf("vec%0d", i), vecs[i].s, vecs[i].p0, vecs[i].abort_at,
                          vecs[i].reason, vecs[i].cnt, vecs[i].snap);
        end

        // Abort during RST returns to IDLE without running
        sel = 1'b0; set_img(0); pc0 = '0;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk); abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        check("rst_abort", 64'({busy, core_rst, stop_reason, cycle_count}),
              64'({1'b0, 1'b1, 2'b11, 16'd0}));

        // Abort during CAPTURE is ignored
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        seen = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk); #1;
            if (snapshot_en) seen = 1;
        end
        check("cap_seen", 64'(seen), 1);
        abort = 1'b1; #1;
        check("cap_abort_snap", 64'(snapshot_en), 1);
        @(negedge clk); abort = 1'b0; #1;
        check("cap_abort_done", 64'({done, stop_reason, cycle_count}), 64'({1'b1, 2'b01, 16'd5}));

        // Asynchronous reset in the middle of RUN
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (5) @(negedge clk);
        #2; rst_n = 1'b0; #1;
        check("async_rst", 64'({core_rst, core_en, snapshot_en, busy, done, stop_reason, cycle_count}),
              64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'd0}));
        @(negedge clk); rst_n = 1'b1;
        run_and_check("after_rst", 1'b0, 0, 0, 2'b01, 5, 1);

        // start held high relaunches straight out of DONE
        @(negedge clk); start = 1'b1;
        seen = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk); #1;
            if (done) seen = 1;
        end
        check("held_done", 64'(seen), 1);
        @(negedge clk); #1;
        check("held_relaunch", 64'({busy, core_rst, cycle_count}), 64'({1'b1, 1'b1, 16'd0}));
        start = 1'b0;
        seen = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk); #1;
            if (done) seen = 1;
        end
        check("held_second_done", 64'({seen, stop_reason, cycle_count}), 64'({1'b1, 2'b01, 16'd5}));

        // Randomized programs against the reference walk
        for (int it = 0; it < 30; it++) begin
            for (int g = 0; g < N; g++)
                img[g] = ($urandom_range(0, 7) == 0) ? '0 : ($urandom() | 32'h1);
            p  = int'($urandom_range(0, N - 1));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : 0;
            s  = 1'($urandom_range(0, 1));
            model(s ? 4 : 60, p, ab, m_reason, m_cnt, m_snap);
            run_and_check($sformatf("rand%0d", it), s, p, ab, m_reason, m_cnt, m_snap);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
